// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: per-button FSM states
// and the bit position of each button on the 4-bit button buses.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PULSE        = 3'd2,
    ST_HELD         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  localparam int unsigned UP    = 32'd0;
  localparam int unsigned DOWN  = 32'd1;
  localparam int unsigned LEFT  = 32'd2;
  localparam int unsigned RIGHT = 32'd3;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchronizer, 5-state debounce FSM and stability counter.
// level/pulse are registered from the next-state decode, so they never see raw directly.
module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned   CW   = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync_meta_r;
  logic          sync_r;
  btn_state_e    state_r;
  btn_state_e    state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;

  // two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= raw;
      sync_r      <= sync_meta_r;
    end
  end

  // next-state and counter logic; each wait state exits at terminal count so cnt never wraps
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (sync_r) begin
          state_next_s = ST_PRESS_WAIT;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_r) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == TERM) begin
          state_next_s = ST_PULSE;
        end else begin
          cnt_next_s = cnt_r + CW'(1);
        end
      end
      ST_PULSE: begin
        if (sync_r) begin
          state_next_s = ST_HELD;
        end else begin
          state_next_s = ST_RELEASE_WAIT;
          cnt_next_s   = '0;
        end
      end
      ST_HELD: begin
        if (!sync_r) begin
          state_next_s = ST_RELEASE_WAIT;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_r) begin
          state_next_s = ST_HELD;
        end else if (cnt_r == TERM) begin
          state_next_s = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // state, counter and registered output decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      level   <= (state_next_s == ST_PULSE) || (state_next_s == ST_HELD) ||
                 (state_next_s == ST_RELEASE_WAIT);
      pulse   <= (state_next_s == ST_PULSE);
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Four independent button debouncers for the game controller; several press
// strobes may fire together, priority is left to the controller.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       btn_any
);

  btn_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .raw(btn_raw[UP]),
    .level(btn_level[UP]), .pulse(btn_pulse[UP])
  );

  btn_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .raw(btn_raw[DOWN]),
    .level(btn_level[DOWN]), .pulse(btn_pulse[DOWN])
  );

  btn_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .rst(rst), .raw(btn_raw[LEFT]),
    .level(btn_level[LEFT]), .pulse(btn_pulse[LEFT])
  );

  btn_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .rst(rst), .raw(btn_raw[RIGHT]),
    .level(btn_level[RIGHT]), .pulse(btn_pulse[RIGHT])
  );

  // the controller's release-wait state waits on this going low
  assign btn_any = |btn_level;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4; "edge k" is the k-th
// rising edge after the inputs change, outputs are sampled on the following falling edge.
module tb_btn_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic       btn_any;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_any  (btn_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 4'b0000;
    @(negedge clk);
    settle(3);
    check("reset_level", btn_level, 4'b0000);
    check("reset_pulse", btn_pulse, 4'b0000);
    check("reset_any", {3'b000, btn_any}, 4'b0000);

    // raw high during reset must not leak through once rst falls
    btn_raw = 4'b1111;
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_level", btn_level, 4'b0000);
    check("post_rst_pulse", btn_pulse, 4'b0000);
    btn_raw = 4'b0000;
    settle(12);
    check("post_rst_clean", btn_level, 4'b0000);

    // press on UP: pulse only after edge 6, level from then on
    btn_raw = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("up_pulse_e%0d", k), btn_pulse, (k == 6) ? 4'b0001 : 4'b0000);
      check($sformatf("up_level_e%0d", k), btn_level, (k >= 6) ? 4'b0001 : 4'b0000);
    end
    btn_raw = 4'b0000;
    settle(10);
    check("up_released", btn_level, 4'b0000);

    // RIGHT high for only 3 cycles: ignored
    btn_raw = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) btn_raw = 4'b0000;
      cyc();
      check($sformatf("glitch_pulse_e%0d", k), btn_pulse, 4'b0000);
      check($sformatf("glitch_level_e%0d", k), btn_level, 4'b0000);
    end

    // LEFT held 50 cycles: one pulse, then release after edge 6 of the low run
    pulse_cnt = 0;
    btn_raw = 4'b0100;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (btn_pulse[2]) pulse_cnt++;
      if (k == 6) check("left_pulse_e6", btn_pulse, 4'b0100);
    end
    check("left_level_held", btn_level, 4'b0100);
    btn_raw = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (btn_pulse[2]) pulse_cnt++;
      check($sformatf("left_rel_level_e%0d", k), btn_level, (k < 6) ? 4'b0100 : 4'b0000);
    end
    check("left_pulse_count", pulse_cnt[3:0], 4'd1);

    // DOWN held, 2-cycle dropout: level stays, no second pulse
    btn_raw = 4'b0010;
    settle(10);
    check("down_held", btn_level, 4'b0010);
    btn_raw = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      if (k == 2) btn_raw = 4'b0010;
      cyc();
      check($sformatf("down_drop_level_e%0d", k), btn_level, 4'b0010);
      check($sformatf("down_drop_pulse_e%0d", k), btn_pulse, 4'b0000);
    end
    btn_raw = 4'b0000;
    settle(10);
    check("down_released", btn_level, 4'b0000);

    // UP and RIGHT together
    btn_raw = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check($sformatf("dual_pulse_e%0d", k), btn_pulse, (k == 6) ? 4'b1001 : 4'b0000);
      check($sformatf("dual_any_e%0d", k), {3'b000, btn_any}, (k >= 6) ? 4'b0001 : 4'b0000);
    end
    btn_raw = 4'b0000;
    settle(10);
    check("dual_any_low", {3'b000, btn_any}, 4'b0000);

    // reset over edges 4 and 5 of a press: restart, pulse after edge 12
    btn_raw = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      if (k == 4) rst = 1'b1;
      if (k == 6) rst = 1'b0;
      cyc();
      check($sformatf("rst_pulse_e%0d", k), btn_pulse, (k == 12) ? 4'b0001 : 4'b0000);
      check($sformatf("rst_level_e%0d", k), btn_level, (k >= 12) ? 4'b0001 : 4'b0000);
    end
    btn_raw = 4'b0000;
    settle(10);
    check("final_idle", btn_level, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
